traffic_intersection: RTL

Parametrised two-road intersection controller: main road and side road, each with its own light, plus a pedestrian walk signal for the side crossing. Main road rests in green. Side road is served only on demand, from a side-road car sensor or a pedestrian button. Every phase change passes through yellow and then an all-red clearance interval. All phase durations are parameters in clock cycles. The block sits at the top of the traffic_light family and drives the light encoders directly.

---
 rtl/traffic_intersection.sv | 121 ++++++++++++
 1 files changed

// File: rtl/traffic_intersection.sv
// traffic_intersection: two-road intersection controller. The main road rests
// in green. The side road is served on demand only, from the car sensor or the
// pedestrian button. Every phase change goes through yellow and then an
// all-red clearance interval.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   side_req     side-road car sensor (level)
//   ped_req      pedestrian button (a 1-cycle pulse is enough)
//   main_light   main road light: red 2'b00, yellow 2'b10, green 2'b11
//   side_light   side road light, same encoding
//   walk         pedestrian walk, high exactly while side_light is green
//   req_pending  latched service request
//   phase        current phase code (0..5)
module traffic_intersection #(
  parameter int MAIN_MIN_GREEN = 10,
  parameter int SIDE_GREEN     = 7,
  parameter int YELLOW         = 4,
  parameter int ALL_RED        = 2,
  parameter int TW             = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [1:0] main_light,
  output logic [1:0] side_light,
  output logic       walk,
  output logic       req_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    RED_A  = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    RED_B  = 3'd5
  } phase_t;

  localparam logic [1:0] RED = 2'b00, YEL = 2'b10, GRN = 2'b11;

  localparam logic [TW-1:0] T_MG = TW'(MAIN_MIN_GREEN - 1);
  localparam logic [TW-1:0] T_SG = TW'(SIDE_GREEN - 1);
  localparam logic [TW-1:0] T_Y  = TW'(YELLOW - 1);
  localparam logic [TW-1:0] T_AR = TW'(ALL_RED - 1);

  phase_t        st, nxt;
  logic [TW-1:0] timer;
  logic          req;

  assign req   = side_req | ped_req;
  assign phase = st;

  // Next phase. Fixed phases leave on the edge where timer == D-1; main green
  // additionally needs a pending request. Codes 6/7 recover through RED_B.
  always_comb begin
    nxt = st;
    case (st)
      MAIN_G: if (timer == T_MG && req_pending) nxt = MAIN_Y;
      MAIN_Y: if (timer == T_Y)  nxt = RED_A;
      RED_A:  if (timer == T_AR) nxt = SIDE_G;
      SIDE_G: if (timer == T_SG) nxt = SIDE_Y;
      SIDE_Y: if (timer == T_Y)  nxt = RED_B;
      RED_B:  if (timer == T_AR) nxt = MAIN_G;
      default: nxt = RED_B;
    endcase
  end

  function automatic logic [1:0] main_of(input phase_t p);
    case (p)
      MAIN_G:  main_of = GRN;
      MAIN_Y:  main_of = YEL;
      default: main_of = RED;
    endcase
  endfunction

  function automatic logic [1:0] side_of(input phase_t p);
    case (p)
      SIDE_G:  side_of = GRN;
      SIDE_Y:  side_of = YEL;
      default: side_of = RED;
    endcase
  endfunction

  // Lights are registered from the next phase so they change on the same
  // edge as the phase register and never depend combinationally on inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= MAIN_G;
      timer       <= '0;
      req_pending <= 1'b0;
      main_light  <= GRN;
      side_light  <= RED;
      walk        <= 1'b0;
    end else begin
      st         <= nxt;
      main_light <= main_of(nxt);
      side_light <= side_of(nxt);
      walk       <= (nxt == SIDE_G);

      // Main green saturates at MAIN_MIN_GREEN-1 so a long idle never wraps.
      if (nxt != st)
        timer <= '0;
      else if (st == MAIN_G && timer == T_MG)
        timer <= timer;
      else
        timer <= timer + 1'b1;

      // Clear on SIDE_G entry wins over a simultaneous set; requests seen
      // during SIDE_G are already being served and are dropped.
      if (nxt == SIDE_G && st != SIDE_G)
        req_pending <= 1'b0;
      else if (req && st != SIDE_G)
        req_pending <= 1'b1;
    end
  end

endmodule
